mst_rx_arbiter: RTL

- Shares the single master (PCIe write) FIFO between the two receive paths (phy1 and phy2 channels).
- Each channel's packetiser pushes framed 18-bit words into its own first-word-fall-through (FWFT) source FIFO.
- This block grants whole frames round-robin and forwards them word-by-word into the master FIFO through a one-stage output register.
- Frames are never interleaved. Malformed or runaway frames are trimmed, and the event is counted.

---
 rtl/mst_rx_arbiter_pkg.sv | 26 ++
 rtl/mst_out_stage.sv | 38 +++
 rtl/mst_rx_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mst_rx_arbiter_pkg.sv
// Shared definitions for the master-FIFO receive arbiter: frame flag
// encodings, FSM states and small helpers for decoding the flag bits.
package mst_rx_arbiter_pkg;

    localparam int FRM_W = 18;

    localparam logic [1:0] FRM_SOP = 2'b10;
    localparam logic [1:0] FRM_MID = 2'b00;
    localparam logic [1:0] FRM_EOP = 2'b01;
    localparam logic [1:0] FRM_ONE = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER0 = 2'd1,
        XFER1 = 2'd2
    } arb_state_e;

    function automatic logic is_sop(input logic [FRM_W-1:0] w);
        return w[FRM_W-1];
    endfunction

    function automatic logic is_eop(input logic [FRM_W-1:0] w);
        return w[FRM_W-2];
    endfunction

endpackage

// File: rtl/mst_out_stage.sv
// One-entry output register in front of a master FIFO write port. A new word
// may be loaded whenever the register is empty or its word is being accepted.
module mst_out_stage #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         full_i,
    output logic         ready_o,
    output logic [W-1:0] dout_o,
    output logic         wr_en_o
);

    logic [W-1:0] dout_q;
    logic         wr_en_q;

    assign ready_o = !wr_en_q || !full_i;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q  <= '0;
            wr_en_q <= 1'b0;
        end else if (ready_o) begin
            wr_en_q <= push_i;
            if (push_i) begin
                dout_q <= din_i;
            end
        end
    end

    assign dout_o  = dout_q;
    assign wr_en_o = wr_en_q;

endmodule

// File: rtl/mst_rx_arbiter.sv
// Round-robin frame arbiter sharing one master FIFO between two FWFT source
// FIFOs; whole frames are forwarded, runaway frames trimmed, events counted.
module mst_rx_arbiter
    import mst_rx_arbiter_pkg::*;
#(
    parameter int MAX_LEN = 64,
    parameter int CNT_W   = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             en,
    input  logic [17:0]      src0_dout,
    input  logic             src0_empty,
    output logic             src0_rd_en,
    input  logic [17:0]      src1_dout,
    input  logic             src1_empty,
    output logic             src1_rd_en,
    output logic [17:0]      mst_din,
    output logic             mst_wr_en,
    input  logic             mst_full,
    output logic [1:0]       grant,
    output logic             busy,
    output logic [CNT_W-1:0] frm_cnt0,
    output logic [CNT_W-1:0] frm_cnt1,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] trunc_cnt
);

    localparam int WCNT_W = $clog2(MAX_LEN + 1);

    arb_state_e        state_q, state_d;
    logic              last_q, last_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0]  frm0_q, frm1_q, drop_q, trunc_q;

    logic              ready;
    logic              push;
    logic [FRM_W-1:0]  push_word;
    logic              pop0, pop1;
    logic              sel_src;
    logic [FRM_W-1:0]  cur_word;
    logic              cur_empty;
    logic              cand0, cand1;
    logic              inc_frm0, inc_frm1, inc_drop, inc_trunc;

    assign cand0 = !src0_empty && is_sop(src0_dout);
    assign cand1 = !src1_empty && is_sop(src1_dout);

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        wcnt_d    = wcnt_q;
        pop0      = 1'b0;
        pop1      = 1'b0;
        push      = 1'b0;
        push_word = '0;
        sel_src   = 1'b0;
        cur_word  = '0;
        cur_empty = 1'b1;
        inc_frm0  = 1'b0;
        inc_frm1  = 1'b0;
        inc_drop  = 1'b0;
        inc_trunc = 1'b0;

        case (state_q)
            IDLE: begin
                // Stray non-SOP heads are flushed before any new grant is made.
                if (!src0_empty && !is_sop(src0_dout)) begin
                    pop0     = 1'b1;
                    inc_drop = 1'b1;
                end else if (!src1_empty && !is_sop(src1_dout)) begin
                    pop1     = 1'b1;
                    inc_drop = 1'b1;
                end else if (en && ready && (cand0 || cand1)) begin
                    sel_src   = cand1 && (!cand0 || !last_q);
                    cur_word  = sel_src ? src1_dout : src0_dout;
                    pop0      = !sel_src;
                    pop1      = sel_src;
                    push      = 1'b1;
                    push_word = cur_word;
                    last_d    = sel_src;
                    wcnt_d    = WCNT_W'(1);
                    if (is_eop(cur_word)) begin
                        inc_frm0 = !sel_src;
                        inc_frm1 = sel_src;
                    end else begin
                        state_d = sel_src ? XFER1 : XFER0;
                    end
                end
            end

            XFER0, XFER1: begin
                sel_src   = (state_q == XFER1);
                cur_word  = sel_src ? src1_dout : src0_dout;
                cur_empty = sel_src ? src1_empty : src0_empty;
                if (!cur_empty && ready) begin
                    pop0      = !sel_src;
                    pop1      = sel_src;
                    push      = 1'b1;
                    push_word = cur_word;
                    wcnt_d    = wcnt_q + WCNT_W'(1);
                    if (is_eop(cur_word)) begin
                        inc_frm0 = !sel_src;
                        inc_frm1 = sel_src;
                        state_d  = IDLE;
                    end else if (wcnt_q == WCNT_W'(MAX_LEN - 1)) begin
                        push_word = {FRM_EOP, cur_word[15:0]};
                        inc_trunc = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            wcnt_q  <= '0;
            frm0_q  <= '0;
            frm1_q  <= '0;
            drop_q  <= '0;
            trunc_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wcnt_q  <= wcnt_d;
            if (inc_frm0)  frm0_q  <= frm0_q + CNT_W'(1);
            if (inc_frm1)  frm1_q  <= frm1_q + CNT_W'(1);
            if (inc_drop)  drop_q  <= drop_q + CNT_W'(1);
            if (inc_trunc) trunc_q <= trunc_q + CNT_W'(1);
        end
    end

    mst_out_stage #(
        .W(FRM_W)
    ) u_out_stage (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .push_i (push),
        .din_i  (push_word),
        .full_i (mst_full),
        .ready_o(ready),
        .dout_o (mst_din),
        .wr_en_o(mst_wr_en)
    );

    assign src0_rd_en = pop0;
    assign src1_rd_en = pop1;
    assign grant      = {state_q == XFER1, state_q == XFER0};
    assign busy       = (state_q != IDLE);
    assign frm_cnt0   = frm0_q;
    assign frm_cnt1   = frm1_q;
    assign drop_cnt   = drop_q;
    assign trunc_cnt  = trunc_q;

endmodule
